// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: opcodes, FSM encodings, flag positions.
// ALU_SEQ_OVF_EN adds the signed-overflow flag.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int FLG_CO = 0;
   localparam int FLG_ZF = 1;
`ifdef ALU_SEQ_OVF_EN
   localparam int FLG_OF = 2;
   localparam int NFLAGS = 3;
`else
   localparam int NFLAGS = 2;
`endif

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus of alu_seq. Both sides use valid/ready: a transfer happens on a
// rising edge where valid and ready are both 1; valid may not drop before that edge.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] In1;
   logic [WIDTH-1:0] In2;
   logic             CI;
   logic [2:0]       A;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] FinalOut;
   logic             CO;
   logic             ZF;
   logic             out_valid;
   logic             out_ready;
`ifdef ALU_SEQ_OVF_EN
   logic             OF;
`endif

   modport master (
      output In1, In2, CI, A, in_valid, out_ready,
      input  in_ready, FinalOut, CO, ZF, out_valid
`ifdef ALU_SEQ_OVF_EN
      , input OF
`endif
   );

   modport slave (
      input  In1, In2, CI, A, in_valid, out_ready,
      output in_ready, FinalOut, CO, ZF, out_valid
`ifdef ALU_SEQ_OVF_EN
      , output OF
`endif
   );

endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// done marks the final iteration; product then carries the finished low WIDTH bits.
module alu_seq_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] partial;

   assign partial = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         mcand_d  = op_a;
         mplier_d = op_b;
         acc_d    = '0;
         cnt_d    = CW'(WIDTH);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = partial;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == CW'(1));
   assign product = partial;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative SLL and MUL.
// Define ALU_SEQ_OVF_EN to add the registered signed-overflow output OF.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic       clk,
   input  logic       rst,
   alu_seq_if.slave   bus,
   output logic [1:0] state_dbg
);
   logic [1:0]        state_q, state_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic [NFLAGS-1:0] flags_q, flags_d;
   logic [WIDTH-1:0]  sll_acc_q, sll_acc_d;
   logic [SHW-1:0]    sll_cnt_q, sll_cnt_d;
   logic              busy_mul_q, busy_mul_d;

   logic              in_ready_c, accept;
   logic              mul_start, mul_busy, mul_done;
   logic [WIDTH-1:0]  mul_product;
   logic [WIDTH:0]    add_sum, sub_sum;
   logic [WIDTH-1:0]  sc_res, new_res;
   logic              sc_co, new_co, load_res;
   logic [SHW-1:0]    shamt;
`ifdef ALU_SEQ_OVF_EN
   logic              sc_of, new_of;
`endif

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .op_a    (bus.In1),
      .op_b    (bus.In2),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // In DONE a new op may enter in the same cycle the result is consumed.
   assign in_ready_c = !rst && !mul_busy &&
                       ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
   assign accept     = bus.in_valid && in_ready_c;
   assign shamt      = bus.In2[SHW-1:0];

   always_comb begin
      add_sum = {1'b0, bus.In1} + {1'b0, bus.In2} + {{WIDTH{1'b0}}, bus.CI};
      sub_sum = {1'b0, bus.In1} + {1'b0, ~bus.In2} + {{WIDTH{1'b0}}, 1'b1};
      sc_res  = '0;
      sc_co   = 1'b0;
      case (bus.A)
         OP_ADD:  begin sc_res = add_sum[WIDTH-1:0]; sc_co = add_sum[WIDTH]; end
         OP_SUB:  begin sc_res = sub_sum[WIDTH-1:0]; sc_co = sub_sum[WIDTH]; end
         OP_AND:  sc_res = bus.In1 & bus.In2;
         OP_OR:   sc_res = bus.In1 | bus.In2;
         OP_XOR:  sc_res = bus.In1 ^ bus.In2;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.In1) < $signed(bus.In2))};
         default: sc_res = '0;
      endcase
`ifdef ALU_SEQ_OVF_EN
      sc_of = 1'b0;
      if (bus.A == OP_ADD)
         sc_of = (bus.In1[WIDTH-1] == bus.In2[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != bus.In1[WIDTH-1]);
      else if (bus.A == OP_SUB)
         sc_of = (bus.In1[WIDTH-1] != bus.In2[WIDTH-1]) &&
                 (sub_sum[WIDTH-1] != bus.In1[WIDTH-1]);
`endif
   end

   always_comb begin
      state_d    = state_q;
      res_d      = res_q;
      flags_d    = flags_q;
      sll_acc_d  = sll_acc_q;
      sll_cnt_d  = sll_cnt_q;
      busy_mul_d = busy_mul_q;
      mul_start  = 1'b0;
      load_res   = 1'b0;
      new_res    = '0;
      new_co     = 1'b0;
`ifdef ALU_SEQ_OVF_EN
      new_of     = 1'b0;
`endif
      case (state_q)
         S_IDLE: state_d = S_IDLE;
         S_BUSY: begin
            if (busy_mul_q) begin
               if (mul_done) begin
                  load_res = 1'b1;
                  new_res  = mul_product;
                  state_d  = S_DONE;
               end
            end else begin
               sll_acc_d = sll_acc_q << 1;
               sll_cnt_d = sll_cnt_q - SHW'(1);
               if (sll_cnt_q == SHW'(1)) begin
                  load_res = 1'b1;
                  new_res  = sll_acc_q << 1;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         case (bus.A)
            OP_SLL: begin
               if (shamt == '0) begin
                  load_res = 1'b1;
                  new_res  = bus.In1;
                  state_d  = S_DONE;
               end else begin
                  sll_acc_d  = bus.In1;
                  sll_cnt_d  = shamt;
                  busy_mul_d = 1'b0;
                  state_d    = S_BUSY;
               end
            end
            OP_MUL: begin
               mul_start  = 1'b1;
               busy_mul_d = 1'b1;
               state_d    = S_BUSY;
            end
            default: begin
               load_res = 1'b1;
               new_res  = sc_res;
               new_co   = sc_co;
`ifdef ALU_SEQ_OVF_EN
               new_of   = sc_of;
`endif
               state_d  = S_DONE;
            end
         endcase
      end

      if (load_res) begin
         res_d          = new_res;
         flags_d        = '0;
         flags_d[FLG_CO] = new_co;
         flags_d[FLG_ZF] = (new_res == '0);
`ifdef ALU_SEQ_OVF_EN
         flags_d[FLG_OF] = new_of;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         res_q      <= '0;
         flags_q    <= '0;
         sll_acc_q  <= '0;
         sll_cnt_q  <= '0;
         busy_mul_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         res_q      <= res_d;
         flags_q    <= flags_d;
         sll_acc_q  <= sll_acc_d;
         sll_cnt_q  <= sll_cnt_d;
         busy_mul_q <= busy_mul_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.FinalOut  = res_q;
   assign bus.CO        = flags_q[FLG_CO];
   assign bus.ZF        = flags_q[FLG_ZF];
`ifdef ALU_SEQ_OVF_EN
   assign bus.OF        = flags_q[FLG_OF];
`endif
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: ops, latencies, back-pressure, reset abort.
module tb_alu_seq;
   localparam int W = 32;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, MUL = 3'b111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] state_dbg;
   int         checks = 0;
   int         errors = 0;

   alu_seq_if #(.WIDTH(W)) bus();

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents one op and holds in_valid until the accepting edge; returns #1 after it.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
      int n;
      n = 0;
      bus.A = op; bus.In1 = a; bus.In2 = b; bus.CI = ci; bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL issue_timeout in_ready=%b required=1", bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.FinalOut !== 32'd0) begin errors++; $display("FAIL rst_finalout got=%h exp=0", bus.FinalOut); end
      checks++; if (bus.CO !== 1'b0 || bus.ZF !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", bus.CO, bus.ZF); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_add();
      int lat;
      issue(ADD, 32'd4325, 32'd464, 1'b0);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
      checks++; if (bus.FinalOut !== 32'd4789) begin errors++; $display("FAIL add_res got=%0d exp=4789", bus.FinalOut); end
      checks++; if (bus.CO !== 1'b0 || bus.ZF !== 1'b0) begin errors++; $display("FAIL add_flags got=%b%b exp=00", bus.CO, bus.ZF); end
      issue(ADD, 32'd4325, 32'd464, 1'b1);
      wait_out(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL addci_latency got=%0d exp=1", lat); end
      checks++; if (bus.FinalOut !== 32'd4790) begin errors++; $display("FAIL addci_res got=%0d exp=4790", bus.FinalOut); end
   endtask

   task automatic test_alu_table();
      logic [2:0]   t_op[11]  = '{SUB, SUB, SLT, SLT, SLT, XOR_, OR_, ADD, SUB, AND_, SLT};
      logic [W-1:0] t_a[11]   = '{32'd4325, 32'd464, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd5,
                                  32'h000000F0, 32'hFFFFFFFF, 32'd5, 32'hFF00FF00, 32'h80000000};
      logic [W-1:0] t_b[11]   = '{32'd464, 32'd4325, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'd5,
                                  32'h0000000F, 32'd1, 32'd5, 32'h0FF00FF0, 32'h7FFFFFFF};
      logic [W-1:0] t_res[11] = '{32'd3861, 32'hFFFFF0EB, 32'd1, 32'd0, 32'd0, 32'd0,
                                  32'h000000FF, 32'd0, 32'd0, 32'h0F000F00, 32'd1};
      logic         t_co[11]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic         t_zf[11]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 11; i++) begin
         issue(t_op[i], t_a[i], t_b[i], 1'b0);
         wait_out(lat);
         checks++;
         if (lat !== 1 || bus.FinalOut !== t_res[i] || bus.CO !== t_co[i] || bus.ZF !== t_zf[i]) begin
            errors++;
            $display("FAIL alu_vec%0d got lat=%0d res=%h co=%b zf=%b exp lat=1 res=%h co=%b zf=%b",
                     i, lat, bus.FinalOut, bus.CO, bus.ZF, t_res[i], t_co[i], t_zf[i]);
         end
      end
   endtask

   task automatic test_mul();
      logic [W-1:0] m_a[3]   = '{32'd4325, 32'hFFFFFFFF, 32'h00010000};
      logic [W-1:0] m_b[3]   = '{32'd464, 32'hFFFFFFFF, 32'h00010000};
      logic [W-1:0] m_res[3] = '{32'd2006800, 32'd1, 32'd0};
      logic         m_zf[3]  = '{1'b0, 1'b0, 1'b1};
      int lat, ir_bad;
      for (int i = 0; i < 3; i++) begin
         issue(MUL, m_a[i], m_b[i], 1'b0);
         lat = 1;
         ir_bad = 0;
         while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0) ir_bad++;
            @(posedge clk); #1; lat++;
         end
         checks++; if (lat !== 33) begin errors++; $display("FAIL mul%0d_latency got=%0d exp=33", i, lat); end
         checks++; if (ir_bad !== 0) begin errors++; $display("FAIL mul%0d_busy_in_ready got=%0d cycles exp=0", i, ir_bad); end
         checks++;
         if (bus.FinalOut !== m_res[i] || bus.CO !== 1'b0 || bus.ZF !== m_zf[i]) begin
            errors++;
            $display("FAIL mul%0d_res got=%h co=%b zf=%b exp=%h co=0 zf=%b", i, bus.FinalOut, bus.CO, bus.ZF, m_res[i], m_zf[i]);
         end
      end
   endtask

   task automatic test_sll();
      logic [W-1:0] s_a[5]   = '{32'd1, 32'd1, 32'd1, 32'd3, 32'hF0000000};
      logic [W-1:0] s_b[5]   = '{32'd5, 32'd0, 32'h00000025, 32'd31, 32'd4};
      logic [W-1:0] s_res[5] = '{32'd32, 32'd1, 32'd32, 32'h80000000, 32'd0};
      int           s_lat[5] = '{6, 1, 6, 32, 5};
      int lat;
      for (int i = 0; i < 5; i++) begin
         issue(SLL, s_a[i], s_b[i], 1'b0);
         wait_out(lat);
         checks++;
         if (lat !== s_lat[i] || bus.FinalOut !== s_res[i] || bus.CO !== 1'b0 || bus.ZF !== (s_res[i] == 32'd0)) begin
            errors++;
            $display("FAIL sll%0d got lat=%0d res=%h co=%b zf=%b exp lat=%0d res=%h", i, lat, bus.FinalOut, bus.CO, bus.ZF, s_lat[i], s_res[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      int unstable;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      issue(ADD, 32'hFFFFFFF0, 32'h00000015, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.FinalOut !== 32'd5 || bus.CO !== 1'b1) begin
         errors++;
         $display("FAIL bp_first got valid=%b res=%h co=%b exp valid=1 res=5 co=1", bus.out_valid, bus.FinalOut, bus.CO);
      end
      bus.A = OR_; bus.In1 = 32'd1; bus.In2 = 32'd2; bus.in_valid = 1'b1;
      unstable = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.FinalOut !== 32'd5 || bus.CO !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
            unstable++;
      end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_hold unstable_cycles got=%0d exp=0", unstable); end
   endtask

   task automatic test_back_to_back();
      bus.A = AND_; bus.In1 = 32'h0000F0F0; bus.In2 = 32'h0000FF00; bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.FinalOut !== 32'h0000F000 || bus.CO !== 1'b0) begin
         errors++;
         $display("FAIL b2b_and got valid=%b res=%h co=%b exp valid=1 res=0000f000 co=0", bus.out_valid, bus.FinalOut, bus.CO);
      end
      bus.A = ADD; bus.In1 = 32'd1; bus.In2 = 32'd1; bus.CI = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.FinalOut !== 32'd2) begin errors++; $display("FAIL b2b_add got valid=%b res=%h exp valid=1 res=2", bus.out_valid, bus.FinalOut); end
      bus.A = XOR_; bus.In1 = 32'd7; bus.In2 = 32'd7;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.FinalOut !== 32'd0 || bus.ZF !== 1'b1) begin errors++; $display("FAIL b2b_xor got valid=%b res=%h zf=%b exp valid=1 res=0 zf=1", bus.out_valid, bus.FinalOut, bus.ZF); end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL b2b_drain got valid=%b state=%0d exp valid=0 state=0", bus.out_valid, state_dbg); end
   endtask

   task automatic test_reset_mid_mul();
      int lat, leaks;
      issue(MUL, 32'd4325, 32'd464, 1'b0);
      repeat (9) begin @(posedge clk); #1; end
      checks++; if (state_dbg !== 2'd1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmm_busy got state=%0d valid=%b exp state=1 valid=0", state_dbg, bus.out_valid); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmm_rst_in_ready got=%b exp=0", bus.in_ready); end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.FinalOut !== 32'd0 || bus.CO !== 1'b0) begin
         errors++;
         $display("FAIL rmm_after got valid=%b ready=%b res=%h co=%b exp valid=0 ready=1 res=0 co=0", bus.out_valid, bus.in_ready, bus.FinalOut, bus.CO);
      end
      leaks = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) leaks++;
      end
      checks++; if (leaks !== 0) begin errors++; $display("FAIL rmm_no_result got=%0d valid_cycles exp=0", leaks); end
      issue(ADD, 32'd2, 32'd3, 1'b0);
      wait_out(lat);
      checks++; if (lat !== 1 || bus.FinalOut !== 32'd5) begin errors++; $display("FAIL rmm_add got lat=%0d res=%h exp lat=1 res=5", lat, bus.FinalOut); end
   endtask

   initial begin
      bus.In1 = '0; bus.In2 = '0; bus.CI = 1'b0; bus.A = 3'b000;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      test_reset();
      test_add();
      test_alu_table();
      test_mul();
      test_sll();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_mul();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
